jk_flip_flop: RTL and testbench

//   Bank of WIDTH independent, positive-edge-triggered JK flip-flops with a

---
 rtl/jk_flip_flop.sv | 55 +++++
 tb/tb_jk_flip_flop.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/jk_flip_flop.sv
// Bank of WIDTH independent positive-edge JK flip-flops with asynchronous
// active-high reset; qn is the bitwise complement of the registered state.
module jk_flip_flop #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             clk,
    output logic [WIDTH-1:0] q,
    input  logic             rst,
    output logic [WIDTH-1:0] qn
);

    // Characteristic table of one JK cell: hold, clear, set, toggle.
    function automatic logic jk_next_bit(
        input logic j_b,
        input logic k_b,
        input logic q_b
    );
        logic r;
        case ({j_b, k_b})
            2'b00:   r = q_b;
            2'b01:   r = 1'b0;
            2'b10:   r = 1'b1;
            2'b11:   r = ~q_b;
            default: r = q_b;
        endcase
        return r;
    endfunction

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next_s;

    // Per-bit next-state; bits never interact.
    always_comb begin
        q_next_s = q_r;
        for (int i = 0; i < WIDTH; i++) begin
            q_next_s[i] = jk_next_bit(j[i], k[i], q_r[i]);
        end
    end

    // State register; reset wins over any coincident clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r <= RESET_VALUE;
        end else begin
            q_r <= q_next_s;
        end
    end

    assign q  = q_r;
    assign qn = ~q_r;

endmodule

// File: tb/tb_jk_flip_flop.sv
// Scoreboard bench: two instances (WIDTH=1 and WIDTH=4, RESET_VALUE=4'b1010)
// driven with directed and random J/K patterns, checked by a decoupled monitor.
module tb_jk_flip_flop;

    localparam logic [3:0] RV4 = 4'b1010;

    typedef struct {
        logic       q1;
        logic [3:0] q4;
        string      tag;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       j1, k1, q1, qn1;
    logic [3:0] j4, k4, q4, qn4;

    exp_t exp_q[$];
    event chk_ev;

    int n_checks;
    int n_pass;

    logic       m1;
    logic [3:0] m4;

    jk_flip_flop dut1 (
        .j(j1), .k(k1), .clk(clk), .q(q1), .rst(rst), .qn(qn1)
    );

    jk_flip_flop #(.WIDTH(4), .RESET_VALUE(RV4)) dut4 (
        .j(j4), .k(k4), .clk(clk), .q(q4), .rst(rst), .qn(qn4)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference behaviour of a single JK bit, written from the truth table.
    function automatic logic ref_bit(input logic jb, input logic kb, input logic qb);
        if (jb && kb) return !qb;
        if (jb)       return 1'b1;
        if (kb)       return 1'b0;
        return qb;
    endfunction

    function automatic logic [3:0] ref_vec(input logic [3:0] jv, input logic [3:0] kv,
                                           input logic [3:0] qv);
        logic [3:0] r;
        for (int b = 0; b < 4; b++) r[b] = ref_bit(jv[b], kv[b], qv[b]);
        return r;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, want, $time);
    endtask

    // Monitor: compare after every clock edge or asynchronous-check request.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or chk_ev);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.tag, "/q1"},  {3'b000, q1},  {3'b000, e.q1});
                check({e.tag, "/qn1"}, {3'b000, qn1}, {3'b000, ~e.q1});
                check({e.tag, "/q4"},  q4,  e.q4);
                check({e.tag, "/qn4"}, qn4, ~e.q4);
            end
        end
    end

    task automatic push(input string tag);
        exp_t e;
        e.q1 = m1;
        e.q4 = m4;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Drive one J/K pattern at the falling edge; expectation is for the next rise.
    task automatic step(input logic jj1, input logic kk1, input logic [3:0] jj4,
                        input logic [3:0] kk4, input string tag);
        @(negedge clk);
        j1 = jj1; k1 = kk1; j4 = jj4; k4 = kk4;
        m1 = ref_bit(jj1, kk1, m1);
        m4 = ref_vec(jj4, kk4, m4);
        push(tag);
    endtask

    // Reset pulse placed strictly between clock edges.
    task automatic mid_reset(input string tag);
        @(posedge clk);
        #3 rst = 1'b1;
        m1 = 1'b0;
        m4 = RV4;
        #1;
        push(tag);
        -> chk_ev;
        #3 rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        j1 = 1'b1; k1 = 1'b0; j4 = 4'hF; k4 = 4'h0;
        m1 = 1'b0;
        m4 = RV4;

        // Reset held with random J/K while the clock runs.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            j1 = 1'($urandom); k1 = 1'($urandom);
            j4 = 4'($urandom); k4 = 4'($urandom);
            push("reset_hold");
            -> chk_ev;
        end

        // Release reset between edges; state holds until the first rising edge.
        @(negedge clk);
        j1 = 1'b1; k1 = 1'b0; j4 = 4'b0011; k4 = 4'b0101;
        rst = 1'b0;
        push("release_hold");
        -> chk_ev;
        m1 = ref_bit(j1, k1, m1);
        m4 = ref_vec(j4, k4, m4);
        push("first_edge");

        step(1'b0, 1'b0, 4'b0000, 4'b0000, "hold_a");
        step(1'b0, 1'b0, 4'b0000, 4'b0000, "hold_b");
        step(1'b0, 1'b1, 4'b0000, 4'b1111, "clear");
        step(1'b1, 1'b0, 4'b1111, 4'b0000, "set");
        step(1'b0, 1'b1, 4'b0101, 4'b1010, "mixed");
        for (int t = 0; t < 4; t++) step(1'b1, 1'b1, 4'b1111, 4'b1111, "toggle");

        step(1'b1, 1'b0, 4'b0101, 4'b0000, "preset");
        mid_reset("mid_reset");
        step(1'b1, 1'b1, 4'b0011, 4'b0101, "after_reset");

        for (int r = 0; r < 200; r++) begin
            if ($urandom_range(0, 15) == 0) begin
                mid_reset("rand_reset");
            end else begin
                step(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), "rand");
            end
        end

        // Drain the scoreboard with a bounded wait.
        begin
            int guard;
            guard = 0;
            while (exp_q.size() > 0 && guard < 5) begin
                @(negedge clk);
                guard++;
            end
            if (exp_q.size() > 0) begin
                n_checks++;
                $display("FAIL drain: %0d entries left expected 0", exp_q.size());
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
